// File: rtl/adc_pkg.sv
// Shared definitions for the ADC decimation path: state encoding, default widths
// and the averaging-exponent clamp.
package adc_pkg;

    localparam int SAMPLE_WIDTH_DEF = 18;
    localparam int MAX_LOG2_AVG_DEF = 8;
    localparam int AXIS_DATA_W      = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    function automatic logic [3:0] clamp_log2(input logic [3:0] v, input logic [3:0] max_v);
        return (v > max_v) ? max_v : v;
    endfunction

endpackage

// File: rtl/adc_decim_accum.sv
// Boxcar accumulator: sums 2^N samples, latches N at group start, produces the averaged word.
// AXIS_ADC_DECIM_ROUND_EN adds a half-LSB bias before the shift (round half toward +inf).
module adc_decim_accum
    import adc_pkg::*;
#(
    parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
    parameter int MAX_LOG2_AVG = MAX_LOG2_AVG_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_clear,
    input  logic                    i_accept,
    input  logic [SAMPLE_WIDTH-1:0] i_sample,
    input  logic [3:0]              i_cfg_log2_avg,
    output logic                    o_is_final,
    output logic [AXIS_DATA_W-1:0]  o_result
);

    localparam int ACC_W = SAMPLE_WIDTH + MAX_LOG2_AVG;
    localparam int CNT_W = MAX_LOG2_AVG + 1;
    localparam logic [3:0] MAX_N = 4'(MAX_LOG2_AVG);

    logic signed [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0]        r_cnt;
    logic [3:0]              r_n_eff;

    logic                    w_first;
    logic [3:0]              w_n_cur;
    logic [CNT_W-1:0]        w_last_idx;
    logic signed [ACC_W-1:0] w_sample_ext;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W:0]   w_rsum;
    logic signed [ACC_W:0]   w_shift;

    assign w_first      = (r_cnt == '0);
    assign w_n_cur      = w_first ? clamp_log2(i_cfg_log2_avg, MAX_N) : r_n_eff;
    assign w_last_idx   = (CNT_W'(1) << w_n_cur) - CNT_W'(1);
    assign o_is_final   = (r_cnt == w_last_idx);
    assign w_sample_ext = $signed({{MAX_LOG2_AVG{i_sample[SAMPLE_WIDTH-1]}}, i_sample});
    assign w_sum        = r_acc + w_sample_ext;

`ifdef AXIS_ADC_DECIM_ROUND_EN
    logic [ACC_W:0] w_bias;
    assign w_bias = (w_n_cur == 4'd0) ? '0 : ((ACC_W+1)'(1) << (w_n_cur - 4'd1));
    assign w_rsum = $signed({w_sum[ACC_W-1], w_sum}) + $signed(w_bias);
`else
    assign w_rsum = $signed({w_sum[ACC_W-1], w_sum});
`endif

    assign w_shift  = w_rsum >>> w_n_cur;
    assign o_result = {{(AXIS_DATA_W-ACC_W-1){w_shift[ACC_W]}}, w_shift};

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_n_eff <= '0;
        end else if (i_accept) begin
            if (w_first) begin
                r_n_eff <= w_n_cur;
            end
            // The closing sample leaves the accumulator empty for the next group.
            if (o_is_final) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else begin
                r_acc <= w_sum;
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/axis_adc_decimator.sv
// AXI-Stream boxcar decimator between the ADC stream and DMA: averages 2^N samples and
// frames results into packets with tlast. Optional rounding via AXIS_ADC_DECIM_ROUND_EN.
//
//   state | meaning
//   IDLE  | cfg_enable low: input dropped, counters held at 0, pending beat drains
//   ACCUM | accumulating groups and emitting averaged beats
module axis_adc_decimator
    import adc_pkg::*;
#(
    parameter int SAMPLE_WIDTH  = SAMPLE_WIDTH_DEF,
    parameter int MAX_LOG2_AVG  = MAX_LOG2_AVG_DEF,
    parameter int PKT_LEN_WIDTH = 16
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     cfg_enable,
    input  logic [3:0]               cfg_log2_avg,
    input  logic [PKT_LEN_WIDTH-1:0] cfg_pkt_len,
    input  logic [AXIS_DATA_W-1:0]   s_axis_tdata,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    output logic [AXIS_DATA_W-1:0]   m_axis_tdata,
    output logic                     m_axis_tvalid,
    output logic                     m_axis_tlast,
    input  logic                     m_axis_tready
);

    localparam int PW = PKT_LEN_WIDTH;

    state_t                 r_state;
    logic                   r_tvalid;
    logic [AXIS_DATA_W-1:0] r_tdata;
    logic                   r_tlast;
    logic [PW-1:0]          r_beat_cnt;
    logic [PW-1:0]          r_pkt_len;

    logic                   w_active;
    logic                   w_accept;
    logic                   w_load;
    logic                   w_is_final;
    logic [AXIS_DATA_W-1:0] w_result;
    logic [PW-1:0]          w_cfg_pkt;
    logic [PW-1:0]          w_pkt_cur;
    logic                   w_beat_last;
    logic                   w_unused_tdata;

    assign w_unused_tdata = ^s_axis_tdata[AXIS_DATA_W-1:SAMPLE_WIDTH];

    // Disable takes effect in the same cycle so a falling enable never closes a group.
    assign w_active = (r_state == ACCUM) && cfg_enable;
    assign s_axis_tready = !areset &&
                           (!w_active || !w_is_final || !r_tvalid || m_axis_tready);
    assign w_accept = w_active && s_axis_tvalid && s_axis_tready;
    assign w_load   = w_accept && w_is_final;

    assign w_cfg_pkt   = (cfg_pkt_len == '0) ? PW'(1) : cfg_pkt_len;
    assign w_pkt_cur   = (r_beat_cnt == '0) ? w_cfg_pkt : r_pkt_len;
    assign w_beat_last = (r_beat_cnt == (w_pkt_cur - PW'(1)));

    adc_decim_accum #(
        .SAMPLE_WIDTH (SAMPLE_WIDTH),
        .MAX_LOG2_AVG (MAX_LOG2_AVG)
    ) u_accum (
        .clk            (aclk),
        .rst            (areset),
        .i_clear        (!w_active),
        .i_accept       (w_accept),
        .i_sample       (s_axis_tdata[SAMPLE_WIDTH-1:0]),
        .i_cfg_log2_avg (cfg_log2_avg),
        .o_is_final     (w_is_final),
        .o_result       (w_result)
    );

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state    <= IDLE;
            r_tvalid   <= 1'b0;
            r_tdata    <= '0;
            r_tlast    <= 1'b0;
            r_beat_cnt <= '0;
            r_pkt_len  <= '0;
        end else begin
            case (r_state)
                IDLE:    r_state <= cfg_enable ? ACCUM : IDLE;
                ACCUM:   r_state <= cfg_enable ? ACCUM : IDLE;
                default: r_state <= IDLE;
            endcase

            if (r_tvalid && m_axis_tready) begin
                r_tvalid <= 1'b0;
            end

            if (w_load) begin
                r_tvalid   <= 1'b1;
                r_tdata    <= w_result;
                r_tlast    <= w_beat_last;
                r_beat_cnt <= w_beat_last ? '0 : (r_beat_cnt + PW'(1));
                if (r_beat_cnt == '0) begin
                    r_pkt_len <= w_pkt_cur;
                end
            end else if (!w_active) begin
                r_beat_cnt <= '0;
            end
        end
    end

    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tlast  = r_tlast;

endmodule

// File: tb/tb_axis_adc_decimator.sv
// Bench for axis_adc_decimator: arithmetic reference model with per-cycle output compare,
// plus directed vectors with literal expectations (rounding literals follow AXIS_ADC_DECIM_ROUND_EN).
module tb_axis_adc_decimator;

    logic        aclk = 1'b0;
    logic        areset;
    logic        cfg_enable;
    logic [3:0]  cfg_log2_avg;
    logic [15:0] cfg_pkt_len;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready;

    axis_adc_decimator dut (
        .aclk          (aclk),
        .areset        (areset),
        .cfg_enable    (cfg_enable),
        .cfg_log2_avg  (cfg_log2_avg),
        .cfg_pkt_len   (cfg_pkt_len),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready)
    );

    always #5 aclk = ~aclk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: integer sums and floor division, group/packet bookkeeping.
    longint      m_sum = 0;
    int          m_cnt = 0;
    int          m_n = 0;
    int          m_beat = 0;
    int          m_pkt = 1;
    logic [32:0] exp_q[$];
    logic [31:0] obs_data[$];
    logic        obs_last[$];
    bit          mon_on = 0;
    bit          expect_valid = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_data;
    logic        prev_last;

    function automatic longint sx18(input logic [31:0] d);
        longint v;
        v = longint'(d[17:0]);
        if (v >= 131072) v = v - 262144;
        return v;
    endfunction

    function automatic longint avg_model(input longint sum, input int n);
        longint div;
        longint s;
        longint q;
        div = longint'(1) << n;
        s = sum;
`ifdef AXIS_ADC_DECIM_ROUND_EN
        s = s + div / 2;
`endif
        q = s / div;
        if ((s % div) != 0 && s < 0) q = q - 1;
        return q;
    endfunction

    always @(negedge aclk) begin
        if (mon_on) begin
            logic [32:0] e;
            logic        lst;
            longint      q;
            if (expect_valid) check("valid_after_final", 32'(m_axis_tvalid), 32'd1);
            if (prev_stall) begin
                check("hold_valid", 32'(m_axis_tvalid), 32'd1);
                check("hold_data", m_axis_tdata, prev_data);
                check("hold_last", 32'(m_axis_tlast), 32'(prev_last));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("beat_data", m_axis_tdata, e[31:0]);
                    check("beat_last", 32'(m_axis_tlast), 32'(e[32]));
                end
                obs_data.push_back(m_axis_tdata);
                obs_last.push_back(m_axis_tlast);
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;

            expect_valid = 0;
            if (!cfg_enable) begin
                m_sum  = 0;
                m_cnt  = 0;
                m_beat = 0;
            end else if (s_axis_tvalid && s_axis_tready) begin
                if (m_cnt == 0) m_n = (cfg_log2_avg > 4'd8) ? 8 : int'(cfg_log2_avg);
                m_sum = m_sum + sx18(s_axis_tdata);
                m_cnt++;
                if (m_cnt == (1 << m_n)) begin
                    q = avg_model(m_sum, m_n);
                    if (m_beat == 0) m_pkt = (cfg_pkt_len == 16'd0) ? 1 : int'(cfg_pkt_len);
                    lst = (m_beat == m_pkt - 1);
                    m_beat = lst ? 0 : m_beat + 1;
                    exp_q.push_back({lst, q[31:0]});
                    m_sum = 0;
                    m_cnt = 0;
                    expect_valid = 1;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic send(input logic [31:0] d);
        int k;
        s_axis_tdata  = d;
        s_axis_tvalid = 1'b1;
        k = 0;
        while (1) begin
            @(negedge aclk);
            if (s_axis_tready) break;
            k++;
            if (k > 2000) begin
                check("send_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 || m_axis_tvalid) begin
            tick(1);
            k++;
            if (k > 5000) begin
                check("drain_timeout", 32'd0, 32'd1);
                break;
            end
        end
        tick(1);
    endtask

    task automatic restart(input logic [3:0] n, input logic [15:0] pl);
        cfg_enable = 1'b0;
        tick(2);
        cfg_log2_avg = n;
        cfg_pkt_len  = pl;
        cfg_enable   = 1'b1;
        tick(2);
    endtask

    initial begin
        int base;
        areset        = 1'b1;
        cfg_enable    = 1'b0;
        cfg_log2_avg  = 4'd0;
        cfg_pkt_len   = 16'd4;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;

        tick(2);
        @(negedge aclk);
        check("rst_s_tready", 32'(s_axis_tready), 32'd0);
        check("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_m_tdata", m_axis_tdata, 32'd0);
        check("rst_m_tlast", 32'(m_axis_tlast), 32'd0);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        mon_on = 1;
        @(negedge aclk);
        check("idle_s_tready", 32'(s_axis_tready), 32'd1);
        tick(1);

        // N=0 pass-through, packets of 4
        restart(4'd0, 16'd4);
        base = obs_data.size();
        for (int i = 1; i <= 5; i++) send(32'(i));
        wait_drain();
        for (int i = 0; i < 5; i++) begin
            check("n0_data", obs_data[base+i], 32'(i + 1));
            check("n0_last", 32'(obs_last[base+i]), 32'(i == 3));
        end

        // N=2, pkt_len 0 behaves as 1; upper tdata bits ignored
        restart(4'd2, 16'd0);
        base = obs_data.size();
        send(32'hFFF0_000A); send(32'd11); send(32'd12); send(32'd13);
        send(32'hFFFF_FFFF); send(32'hFFFF_FFFF); send(32'hFFFF_FFFF); send(32'hFFFF_FFFE);
        wait_drain();
`ifdef AXIS_ADC_DECIM_ROUND_EN
        check("n2_pos", obs_data[base], 32'd12);
        check("n2_neg", obs_data[base+1], 32'hFFFF_FFFF);
`else
        check("n2_pos", obs_data[base], 32'd11);
        check("n2_neg", obs_data[base+1], 32'hFFFF_FFFE);
`endif
        check("n2_last", 32'(obs_last[base] && obs_last[base+1]), 32'd1);

        // Backpressure: output full, 4th sample of second group must stall
        m_axis_tready = 1'b0;
        base = obs_data.size();
        for (int i = 1; i <= 7; i++) send(32'(i));
        s_axis_tdata  = 32'd8;
        s_axis_tvalid = 1'b1;
        repeat (5) begin
            @(negedge aclk);
            check("stall_s_tready", 32'(s_axis_tready), 32'd0);
            check("stall_m_tvalid", 32'(m_axis_tvalid), 32'd1);
        end
        @(posedge aclk);
        #1;
        m_axis_tready = 1'b1;
        send(32'd8);
        wait_drain();
`ifdef AXIS_ADC_DECIM_ROUND_EN
        check("bp_first", obs_data[base], 32'd3);
        check("bp_second", obs_data[base+1], 32'd7);
`else
        check("bp_first", obs_data[base], 32'd2);
        check("bp_second", obs_data[base+1], 32'd6);
`endif

        // Full scale at N=8, then exponent 12 clamped to 8
        restart(4'd8, 16'd1);
        base = obs_data.size();
        repeat (256) send(32'h0001_FFFF);
        cfg_log2_avg = 4'd12;
        repeat (256) send(32'h0002_0000);
        wait_drain();
        check("fs_pos", obs_data[base], 32'h0001_FFFF);
        check("fs_neg_clamp", obs_data[base+1], 32'hFFFE_0000);

        // Exponent change mid-group takes effect on the next group
        restart(4'd2, 16'd1);
        base = obs_data.size();
        send(32'd0); send(32'd4);
        cfg_log2_avg = 4'd3;
        send(32'd8); send(32'd12);
        for (int i = 1; i <= 8; i++) send(32'(i));
        wait_drain();
        check("ncfg_count", 32'(obs_data.size() - base), 32'd2);
        check("ncfg_first", obs_data[base], 32'd6);
`ifdef AXIS_ADC_DECIM_ROUND_EN
        check("ncfg_second", obs_data[base+1], 32'd5);
`else
        check("ncfg_second", obs_data[base+1], 32'd4);
`endif

        // Disable with a partial group: no beat, next group clean
        restart(4'd2, 16'd1);
        base = obs_data.size();
        send(32'd100); send(32'd100); send(32'd100);
        cfg_enable = 1'b0;
        tick(3);
        cfg_enable = 1'b1;
        tick(2);
        send(32'd20); send(32'd21); send(32'd22); send(32'd23);
        wait_drain();
        check("dis_count", 32'(obs_data.size() - base), 32'd1);
`ifdef AXIS_ADC_DECIM_ROUND_EN
        check("dis_value", obs_data[base], 32'd22);
`else
        check("dis_value", obs_data[base], 32'd21);
`endif
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
